// File: rtl/bsg_cache_amo_rmw.sv
// Read-modify-write engine for cache atomics: read, compute and masked write against a
// 64-bit synchronous data memory, returning the pre-operation value.

package bsg_cache_pkg;

  typedef struct packed {
    logic [1:0] data_size_op;
    logic       atomic_op;
    logic       amoswap_op;
    logic       amoadd_op;
    logic       amoxor_op;
    logic       amoand_op;
    logic       amoor_op;
    logic       amomin_op;
    logic       amomax_op;
    logic       amominu_op;
    logic       amomaxu_op;
  } bsg_cache_decode_s;

endpackage

module bsg_cache_amo_rmw
  import bsg_cache_pkg::*;
#(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  bsg_cache_decode_s         decode_i,
  input  logic [addr_width_p-1:0]   addr_i,
  input  logic [data_width_p-1:0]   data_i,
  output logic                      mem_v_o,
  output logic                      mem_w_o,
  output logic [addr_width_p-4:0]   mem_addr_o,
  output logic [data_width_p-1:0]   mem_data_o,
  output logic [data_width_p/8-1:0] mem_mask_o,
  input  logic [data_width_p-1:0]   mem_data_i,
  output logic                      v_o,
  output logic [data_width_p-1:0]   data_o,
  input  logic                      yumi_i
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    dbl_q, dbl_d;
  logic                    lane_q, lane_d;
  logic [8:0]              amo_q, amo_d;
  logic [addr_width_p-4:0] idx_q, idx_d;
  logic [data_width_p-1:0] operand_q, operand_d;
  logic [data_width_p-1:0] old_q, old_d;

  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    state_d   = state_q;
    dbl_d     = dbl_q;
    lane_d    = lane_q;
    amo_d     = amo_q;
    idx_d     = idx_q;
    operand_d = operand_q;
    old_d     = old_q;
    unique case (state_q)
      StIdle: begin
        if (v_i) begin
          dbl_d     = (decode_i.data_size_op == 2'b11);
          lane_d    = addr_i[2];
          amo_d     = {decode_i.amomaxu_op, decode_i.amominu_op, decode_i.amomax_op,
                       decode_i.amomin_op, decode_i.amoor_op, decode_i.amoand_op,
                       decode_i.amoxor_op, decode_i.amoadd_op, decode_i.amoswap_op};
          idx_d     = addr_i[addr_width_p-1:3];
          operand_d = data_i;
          if (decode_i.atomic_op) begin
            state_d = StRead;
          end else begin
            old_d   = '0;
            state_d = StDone;
          end
        end
      end
      StRead:  state_d = StWait;
      StWait: begin
        old_d   = mem_data_i;
        state_d = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  if (yumi_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      dbl_q     <= 1'b0;
      lane_q    <= 1'b0;
      amo_q     <= '0;
      idx_q     <= '0;
      operand_q <= '0;
      old_q     <= '0;
    end else begin
      state_q   <= state_d;
      dbl_q     <= dbl_d;
      lane_q    <= lane_d;
      amo_q     <= amo_d;
      idx_q     <= idx_d;
      operand_q <= operand_d;
      old_q     <= old_d;
    end
  end

  logic [63:0] a64, b64, res64;
  logic [31:0] a32, b32, res32;

  // Both widths are computed in parallel; dbl_q picks one. No amo bit set falls to swap.
  always_comb begin
    a64   = old_q;
    b64   = operand_q;
    a32   = lane_q ? old_q[63:32] : old_q[31:0];
    b32   = operand_q[31:0];
    res64 = b64;
    res32 = b32;
    unique case (1'b1)
      amo_q[0]: begin res64 = b64;       res32 = b32;       end
      amo_q[1]: begin res64 = a64 + b64; res32 = a32 + b32; end
      amo_q[2]: begin res64 = a64 ^ b64; res32 = a32 ^ b32; end
      amo_q[3]: begin res64 = a64 & b64; res32 = a32 & b32; end
      amo_q[4]: begin res64 = a64 | b64; res32 = a32 | b32; end
      amo_q[5]: begin
        res64 = ($signed(b64) < $signed(a64)) ? b64 : a64;
        res32 = ($signed(b32) < $signed(a32)) ? b32 : a32;
      end
      amo_q[6]: begin
        res64 = ($signed(b64) > $signed(a64)) ? b64 : a64;
        res32 = ($signed(b32) > $signed(a32)) ? b32 : a32;
      end
      amo_q[7]: begin
        res64 = (b64 < a64) ? b64 : a64;
        res32 = (b32 < a32) ? b32 : a32;
      end
      amo_q[8]: begin
        res64 = (b64 > a64) ? b64 : a64;
        res32 = (b32 > a32) ? b32 : a32;
      end
      default: begin res64 = b64; res32 = b32; end
    endcase
  end

  always_comb begin
    ready_o    = (state_q == StIdle);
    mem_v_o    = (state_q == StRead) || (state_q == StWrite);
    mem_w_o    = (state_q == StWrite);
    mem_addr_o = mem_v_o ? idx_q : '0;
    mem_data_o = '0;
    mem_mask_o = '0;
    if (state_q == StWrite) begin
      mem_data_o = dbl_q ? res64 : {res32, res32};
      mem_mask_o = dbl_q ? 8'hFF : (lane_q ? 8'hF0 : 8'h0F);
    end
    v_o    = (state_q == StDone);
    data_o = '0;
    if (v_o) data_o = dbl_q ? old_q : {{32{a32[31]}}, a32};
  end

endmodule

// File: tb/tb_bsg_cache_amo_rmw.sv
// Directed bench for bsg_cache_amo_rmw: a transaction-level model predicts every output on
// every cycle, and literal expectations pin the model on the documented examples.

module tb_bsg_cache_amo_rmw;
  import bsg_cache_pkg::*;

  localparam int OpSwap = 0, OpAdd = 1, OpXor = 2, OpAnd = 3, OpOr = 4;
  localparam int OpMin = 5, OpMax = 6, OpMinu = 7, OpMaxu = 8, OpNone = 9, OpLoad = 10;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic v_i = 1'b0;
  logic ready_o;
  bsg_cache_decode_s decode_i = '0;
  logic [31:0] addr_i = '0;
  logic [63:0] data_i = '0;
  logic mem_v_o, mem_w_o;
  logic [28:0] mem_addr_o;
  logic [63:0] mem_data_o;
  logic [7:0]  mem_mask_o;
  logic [63:0] mem_data_i = '0;
  logic v_o;
  logic [63:0] data_o;
  logic yumi_i = 1'b0;

  always #5 clk = ~clk;

  bsg_cache_amo_rmw #(.addr_width_p(32), .data_width_p(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .decode_i(decode_i),
    .addr_i(addr_i), .data_i(data_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o),
    .mem_data_i(mem_data_i), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%016h, expected 0x%016h", name, $time, act, exp);
    end
  endtask

  // Memory seen by the DUT, and the model's own view of memory.
  logic [63:0] bmem [0:31];
  logic [63:0] mdl_mem [0:31];
  int n_writes = 0;
  logic [63:0] last_wdata = '0, last_rsp = '0;
  logic [7:0]  last_mask = '0;

  always @(posedge clk) begin
    if (mem_v_o && mem_w_o) begin
      for (int b = 0; b < 8; b++)
        if (mem_mask_o[b]) bmem[mem_addr_o[4:0]][b*8 +: 8] <= mem_data_o[b*8 +: 8];
      last_wdata <= mem_data_o;
      last_mask  <= mem_mask_o;
      n_writes   <= n_writes + 1;
    end else if (mem_v_o) begin
      mem_data_i <= bmem[mem_addr_o[4:0]];
    end
    if (v_o && yumi_i) last_rsp <= data_o;
  end

  function automatic logic [63:0] calc(input int op, input logic [63:0] a,
                                       input logic [63:0] b, input bit dbl);
    longint sa, sb;
    logic [63:0] ua, ub, r;
    if (dbl) begin
      sa = a; sb = b; ua = a; ub = b;
    end else begin
      sa = longint'($signed(a[31:0])); sb = longint'($signed(b[31:0]));
      ua = {32'h0, a[31:0]}; ub = {32'h0, b[31:0]};
    end
    case (op)
      OpAdd:   r = a + b;
      OpXor:   r = a ^ b;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpMin:   r = (sb < sa) ? b : a;
      OpMax:   r = (sb > sa) ? b : a;
      OpMinu:  r = (ub < ua) ? b : a;
      OpMaxu:  r = (ub > ua) ? b : a;
      default: r = b;
    endcase
    return dbl ? r : {32'h0, r[31:0]};
  endfunction

  // Transaction model: cycle count since acceptance plus the predicted results.
  bit          m_busy = 0, m_atomic = 0;
  int          m_cyc = 0;
  int          m_op = 0;
  bit          m_dbl = 0;
  logic [28:0] m_idx = '0;
  logic [63:0] m_wdata = '0, m_newmem = '0, m_rsp = '0;
  logic [7:0]  m_mask = '0;

  logic exp_v, exp_mv;
  assign exp_v  = m_busy && (m_atomic ? (m_cyc >= 4) : (m_cyc >= 1));
  assign exp_mv = m_busy && m_atomic && (m_cyc == 1 || m_cyc == 3);

  always @(posedge clk) begin
    logic [63:0] old, r;
    logic [31:0] lane_old;
    bit lane;
    if (reset_i) begin
      m_busy <= 0;
      m_cyc  <= 0;
    end else if (m_busy) begin
      if (m_atomic && m_cyc == 3) mdl_mem[m_idx[4:0]] <= m_newmem;
      if (exp_v && yumi_i) m_busy <= 0;
      else m_cyc <= m_cyc + 1;
    end else if (v_i) begin
      m_busy   <= 1;
      m_cyc    <= 1;
      m_atomic <= decode_i.atomic_op;
      m_idx    <= addr_i[31:3];
      old       = mdl_mem[addr_i[7:3]];
      lane      = addr_i[2];
      lane_old  = lane ? old[63:32] : old[31:0];
      if (!decode_i.atomic_op) begin
        m_rsp <= '0;
      end else if (decode_i.data_size_op == 2'b11) begin
        r         = calc(m_op_of(decode_i), old, data_i, 1'b1);
        m_wdata  <= r;
        m_mask   <= 8'hFF;
        m_newmem <= r;
        m_rsp    <= old;
      end else begin
        r         = calc(m_op_of(decode_i), {32'h0, lane_old}, data_i, 1'b0);
        m_wdata  <= {r[31:0], r[31:0]};
        m_mask   <= lane ? 8'hF0 : 8'h0F;
        m_newmem <= lane ? {r[31:0], old[31:0]} : {old[63:32], r[31:0]};
        m_rsp    <= {{32{lane_old[31]}}, lane_old};
      end
    end
  end

  function automatic int m_op_of(input bsg_cache_decode_s d);
    if (d.amoadd_op)  return OpAdd;
    if (d.amoxor_op)  return OpXor;
    if (d.amoand_op)  return OpAnd;
    if (d.amoor_op)   return OpOr;
    if (d.amomin_op)  return OpMin;
    if (d.amomax_op)  return OpMax;
    if (d.amominu_op) return OpMinu;
    if (d.amomaxu_op) return OpMaxu;
    return OpSwap;
  endfunction

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      bit wr;
      wr = m_busy && m_atomic && (m_cyc == 3);
      check("ready_o",    {63'h0, ready_o}, {63'h0, !m_busy});
      check("mem_v_o",    {63'h0, mem_v_o}, {63'h0, exp_mv});
      check("mem_w_o",    {63'h0, mem_w_o}, {63'h0, wr});
      check("mem_addr_o", {35'h0, mem_addr_o}, exp_mv ? {35'h0, m_idx} : 64'h0);
      check("mem_data_o", mem_data_o, wr ? m_wdata : 64'h0);
      check("mem_mask_o", {56'h0, mem_mask_o}, wr ? {56'h0, m_mask} : 64'h0);
      check("v_o",        {63'h0, v_o}, {63'h0, exp_v});
      check("data_o",     data_o, exp_v ? m_rsp : 64'h0);
    end
  end

  function automatic bsg_cache_decode_s mk_dec(input int op, input bit dbl);
    bsg_cache_decode_s d;
    d = '0;
    d.data_size_op = dbl ? 2'b11 : 2'b10;
    d.atomic_op    = (op != OpLoad);
    case (op)
      OpSwap: d.amoswap_op = 1'b1;
      OpAdd:  d.amoadd_op  = 1'b1;
      OpXor:  d.amoxor_op  = 1'b1;
      OpAnd:  d.amoand_op  = 1'b1;
      OpOr:   d.amoor_op   = 1'b1;
      OpMin:  d.amomin_op  = 1'b1;
      OpMax:  d.amomax_op  = 1'b1;
      OpMinu: d.amominu_op = 1'b1;
      OpMaxu: d.amomaxu_op = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  task automatic issue(input int op, input bit dbl, input logic [31:0] a, input logic [63:0] d);
    int cnt = 0;
    while (!ready_o && cnt < 20) begin @(posedge clk); #1; cnt++; end
    if (!ready_o) begin n_checks++; n_fail++; $display("FAIL ready_timeout got 0 expected 1"); end
    v_i = 1'b1; decode_i = mk_dec(op, dbl); addr_i = a; data_i = d;
    @(posedge clk); #1;
    v_i = 1'b0; decode_i = '0; addr_i = '0; data_i = '0;
  endtask

  task automatic finish_rsp(input int hold);
    int cnt = 0;
    while (!v_o && cnt < 20) begin @(posedge clk); #1; cnt++; end
    if (!v_o) begin n_checks++; n_fail++; $display("FAIL rsp_timeout got v_o=0 expected 1"); end
    repeat (hold) begin @(posedge clk); #1; end
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
  endtask

  task automatic run(input int op, input bit dbl, input logic [31:0] a, input logic [63:0] d);
    issue(op, dbl, a, d);
    finish_rsp(0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 32; i++) begin bmem[i] = '0; mdl_mem[i] = '0; end
    bmem[8]  = 64'h0000_0001_FFFF_FFFF; mdl_mem[8]  = 64'h0000_0001_FFFF_FFFF;
    bmem[10] = 64'h0000_0000_FFFF_FFFF; mdl_mem[10] = 64'h0000_0000_FFFF_FFFF;
    bmem[11] = 64'h7FFF_FFFF_FFFF_FFFF; mdl_mem[11] = 64'h7FFF_FFFF_FFFF_FFFF;
    bmem[12] = 64'h8000_0000_0000_0000; mdl_mem[12] = 64'h8000_0000_0000_0000;
    bmem[13] = 64'hFF00_FF00_FF00_FF00; mdl_mem[13] = 64'hFF00_FF00_FF00_FF00;
    bmem[14] = 64'hFFFF_0000_AAAA_5555; mdl_mem[14] = 64'hFFFF_0000_AAAA_5555;
    bmem[15] = 64'h5555_5555_7000_0000; mdl_mem[15] = 64'h5555_5555_7000_0000;

    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) begin @(posedge clk); #1; end
    reset_i = 1'b0;

    run(OpAdd, 1, 32'h40, 64'h1);
    check("add_d_wdata", last_wdata, 64'h0000_0002_0000_0000);
    check("add_d_mask",  {56'h0, last_mask}, 64'hFF);
    check("add_d_rsp",   last_rsp, 64'h0000_0001_FFFF_FFFF);

    run(OpSwap, 1, 32'h40, 64'h8000_0000_1111_1111);
    check("swap_d_rsp", last_rsp, 64'h0000_0002_0000_0000);
    run(OpSwap, 0, 32'h44, 64'h1234_5678);
    check("swap_w_wdata", last_wdata, 64'h1234_5678_1234_5678);
    check("swap_w_mask",  {56'h0, last_mask}, 64'hF0);
    check("swap_w_rsp",   last_rsp, 64'hFFFF_FFFF_8000_0000);

    run(OpMin, 0, 32'h50, 64'h5);
    check("min_w_wdata", last_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("min_w_mask",  {56'h0, last_mask}, 64'h0F);
    run(OpMinu, 0, 32'h50, 64'h5);
    check("minu_w_wdata", last_wdata, 64'h0000_0005_0000_0005);
    check("minu_w_rsp",   last_rsp, 64'hFFFF_FFFF_FFFF_FFFF);

    run(OpMaxu, 1, 32'h58, 64'h8000_0000_0000_0000);
    check("maxu_d_wdata", last_wdata, 64'h8000_0000_0000_0000);
    check("maxu_d_rsp",   last_rsp, 64'h7FFF_FFFF_FFFF_FFFF);
    run(OpMax, 1, 32'h60, 64'h8000_0000_0000_0000);
    check("max_d_eq_wdata", last_wdata, 64'h8000_0000_0000_0000);

    issue(OpXor, 1, 32'h68, 64'h0F0F_0F0F_0F0F_0F0F);
    finish_rsp(10);
    check("xor_d_wdata", last_wdata, 64'hF00F_F00F_F00F_F00F);
    w0 = n_writes;
    run(OpLoad, 0, 32'h68, 64'h0);
    check("lw_no_write", 64'(n_writes), 64'(w0));
    check("lw_rsp",      last_rsp, 64'h0);

    issue(OpAnd, 1, 32'h70, 64'h0);
    #0;
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    check("reset_no_write", 64'(n_writes), 64'(w0));
    @(posedge clk); #1;
    check("reset_mem_kept", bmem[14], 64'hFFFF_0000_AAAA_5555);
    run(OpOr, 0, 32'h74, 64'h0000_1234);
    check("or_w_wdata", last_wdata, 64'hFFFF_1234_FFFF_1234);
    check("or_w_rsp",   last_rsp, 64'hFFFF_FFFF_FFFF_0000);

    reset_i = 1'b1; v_i = 1'b1; decode_i = mk_dec(OpAdd, 1); addr_i = 32'h78; data_i = 64'h1;
    @(posedge clk); #1;
    reset_i = 1'b0; v_i = 1'b0; decode_i = '0;
    @(posedge clk); #1;
    check("reset_drops_req", {63'h0, ready_o}, 64'h1);

    run(OpNone, 0, 32'h78, 64'hCAFE_F00D);
    check("none_w_wdata", last_wdata, 64'hCAFE_F00D_CAFE_F00D);
    check("none_w_rsp",   last_rsp, 64'h0000_0000_7000_0000);

    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_cache_amo_rmw.md
# bsg_cache_amo_rmw

Multi-cycle read-modify-write engine for cache atomics. It accepts one decoded atomic request (a `bsg_cache_decode_s` produced by the opcode decoder, plus address and operand) and performs a read, compute and masked write against a 64-bit synchronous data memory. It returns the pre-operation memory value to the response side. It sits directly downstream of the opcode decoder, in the atomic path between the tag-hit stage and the data SRAM port.

## Interface
- `addr_width_p`, default 32: byte-address width.
- `data_width_p`, default 64: data width. Only 64 is supported.
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `v_i`, in, 1: request valid.
- `ready_o`, out, 1: request accepted when `v_i & ready_o`.
- `decode_i`, in, `bsg_cache_decode_s`: decoded opcode. Uses `atomic_op`, the `amo*_op` one-hots and `data_size_op` (2'b10 = word, 2'b11 = double).
- `addr_i`, in, `addr_width_p`: byte address.
- `data_i`, in, 64: operand. Word ops use `[31:0]`.
- `mem_v_o`, out, 1: memory access this cycle. The memory always accepts.
- `mem_w_o`, out, 1: 1 = write, 0 = read.
- `mem_addr_o`, out, `addr_width_p-3`: word index, equal to `addr[addr_width_p-1:3]`.
- `mem_data_o`, out, 64: write data.
- `mem_mask_o`, out, 8: byte write mask.
- `mem_data_i`, in, 64: read data, valid the cycle after a read.
- `v_o`, out, 1: response valid.
- `data_o`, out, 64: old memory value.
- `yumi_i`, in, 1: response consumed. Legal only while `v_o` is high.

## Operation
- The FSM has five states: IDLE, READ, WAIT, WRITE, DONE.
- **IDLE**
  - `ready_o` = 1.
  - On `v_i` with `atomic_op` = 1: latch decode, address and operand; go to READ.
  - On `v_i` with `atomic_op` = 0: accept, do no memory access, set `old_r` = 0; go to DONE.
- **READ**: `mem_v_o` = 1, `mem_w_o` = 0, `mem_addr_o` = latched index. Next state is WAIT.
- **WAIT**: capture `mem_data_i` into `old_r`. Next state is WRITE.
- **WRITE**: `mem_v_o` = 1, `mem_w_o` = 1, `mem_data_o` = result, `mem_mask_o` as below. Next state is DONE.
- **DONE**: `v_o` = 1. On `yumi_i`, go to IDLE.
- **Double ops**
  - Operand a = `old_r`, b = operand (both 64-bit).
  - `mem_mask_o` = 8'hFF.
  - `mem_data_o` = result.
- **Word ops**
  - Lane select is latched `addr[2]`: 1 = upper 32 bits, 0 = lower 32 bits.
  - a = selected 32-bit lane of `old_r`; b = `operand[31:0]`.
  - `mem_mask_o` = 8'hF0 for the upper lane, 8'h0F for the lower lane.
  - `mem_data_o` = {result32, result32}.
  - Address bits [1:0] are ignored; misalignment is not checked.
- **Compute at the operation width**, with wrapping arithmetic:
  - swap = b
  - add = a + b (carry discarded)
  - and = a & b, or = a | b, xor = a ^ b
  - min / max: signed compare
  - minu / maxu: unsigned compare
  - On equal operands, min and max return a.
- **`data_o`**
  - Double: `old_r`.
  - Word: selected lane sign-extended to 64 bits (atomics are sign-extending).
  - Non-atomic request: 0.
  - Held stable throughout DONE.
- A request with `atomic_op` = 1 and no `amo*` bit set is treated as swap.
- Latched request fields are held from acceptance until return to IDLE. Inputs are ignored outside IDLE.

## Timing
- **Reset**
  - State goes to IDLE; all latched registers clear to 0.
  - Output values during and after reset: `ready_o` = 1, `mem_v_o` = 0, `mem_w_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0, `mem_mask_o` = 0, `v_o` = 0, `data_o` = 0.
  - Reset in any state aborts the operation next edge. A pending write is never issued.
  - Reset asserted in the same cycle as `v_i` wins; the request is dropped.
- **Atomic request**, accepted at edge 0:
  - READ during cycle 1.
  - WAIT during cycle 2.
  - WRITE during cycle 3.
  - `v_o` first high in cycle 4.
  - Minimum latency is 4 cycles; throughput is at most one op per 5 cycles.
- **Non-atomic request**: `v_o` is high in the cycle after acceptance.
- **Response handshake**
  - `v_o` stays high until `yumi_i`. Back-pressure is unbounded.
  - `ready_o` is 0 in every state except IDLE, so there is no accept on the same edge as `yumi_i`.
- Memory outputs are 0 whenever `mem_v_o` = 0.
- The read-to-write window of the same word is three cycles. The block provides no forwarding; upstream must not issue a conflicting access in that window.
- All outputs are registered-state decodes, with no combinational path from inputs. `ready_o` depends only on state.

## Test plan
- **AMOADD_D**
  - Stimulus: addr 0x40, mem[8] = 0x0000_0001_FFFF_FFFF, data 1.
  - Required: read at cycle 1; write at cycle 3 of 0x0000_0002_0000_0000 with mask 8'hFF; `v_o` at cycle 4 with `data_o` = 0x0000_0001_FFFF_FFFF.
- **AMOSWAP_W, upper lane**
  - Stimulus: addr 0x44, mem = 0x8000_0000_1111_1111, data 0x1234_5678.
  - Required: write {0x1234_5678, 0x1234_5678} with mask 8'hF0; `data_o` = 0xFFFF_FFFF_8000_0000.
- **AMOMIN_W vs AMOMINU_W, lower lane**
  - Stimulus: old 0xFFFF_FFFF, operand 0x0000_0005.
  - Required: signed min writes 0xFFFF_FFFF (mask 8'h0F); unsigned min writes 0x0000_0005.
- **AMOMAXU_D, and AMOMAX_D on equal operands**
  - Stimulus: AMOMAXU_D with old 0x7FFF…, operand 0x8000…; AMOMAX_D with equal operands.
  - Required: AMOMAXU_D writes 0x8000…; AMOMAX_D writes a unchanged.
- **Back-pressure and non-atomic**
  - Stimulus: hold `yumi_i` = 0 for 10 cycles; then present an LW.
  - Required: `v_o` and `data_o` stable and `ready_o` = 0 throughout the hold; after `yumi_i`, `ready_o` = 1 next cycle. The LW produces no `mem_v_o` and gives `v_o` next cycle with `data_o` = 0.
- **Reset mid-operation**
  - Stimulus: assert `reset_i` in WAIT.
  - Required: no write issued; next cycle all outputs are at reset values; the next request completes normally.
